// File: rtl/jb_prach_pkg.sv
// Shared types for the PRACH antenna deinterleaver.
package jb_prach_pkg;

    typedef enum logic {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } s2p_state_t;

    // Default component width. Blocks with a different PRECISION declare a
    // local typedef of the same shape: logic [2*PRECISION-1:0].
    localparam int IQ_PRECISION = 16;
    typedef logic [2*IQ_PRECISION-1:0] iq_sample_t;

endpackage

// File: rtl/jb_prach_sat_cnt.sv
// Saturating up-counter. A clear wins over an increment in the same cycle.
module jb_prach_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/jb_prach_s2p_seq.sv
// PRACH antenna deinterleaver: gathers a TDM stream of antenna-tagged IQ
// beats into complete frames and presents them on per-antenna lanes.
//
// state   | meaning
// --------+----------------------------------------------------------
// SYNC    | waiting for an antenna-0 beat; other indices are dropped
// COLLECT | frame open, expecting antenna exp_idx next
module jb_prach_s2p_seq
    import jb_prach_pkg::*;
#(
    parameter int N_ANTENNAS = 4,
    parameter int PRECISION  = 16,
    parameter int USR_ID_BW  = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                   clk_4x,
    input  logic                   reset_4x,
    input  logic [USR_ID_BW-1:0]   ant_num_m1,
    input  logic                   err_clr,
    input  logic                   tvalid_in,
    input  logic [2*PRECISION-1:0] tdata_in,
    input  logic [USR_ID_BW-1:0]   tuser_in,
    output logic [N_ANTENNAS-1:0]  tvalid_out,
    output logic [2*PRECISION-1:0] tdata_out [N_ANTENNAS],
    output logic                   frame_err,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    typedef logic [2*PRECISION-1:0] iq_t;

    localparam logic [USR_ID_BW-1:0] LAST_LANE = USR_ID_BW'(N_ANTENNAS - 1);

    s2p_state_t            state_q, state_d;
    logic [USR_ID_BW-1:0]  exp_idx_q, exp_idx_d;
    logic [USR_ID_BW-1:0]  n_m1_lat_q, n_m1_lat_d;
    iq_t                   stage_q [N_ANTENNAS];
    iq_t                   stage_d [N_ANTENNAS];
    iq_t                   tdata_q [N_ANTENNAS];
    iq_t                   tdata_d [N_ANTENNAS];
    logic [N_ANTENNAS-1:0] tvalid_q, tvalid_d;
    logic                  frame_err_q, frame_err_d;

    logic [USR_ID_BW-1:0]  ant_clamped;
    logic [USR_ID_BW-1:0]  last_idx;
    logic                  start;
    logic                  complete;

    // Requested antenna count limited to the physical lanes.
    assign ant_clamped = (ant_num_m1 > LAST_LANE) ? LAST_LANE : ant_num_m1;

    // Sequencing: frame start, in-order collection, violation handling and
    // frame completion. The final beat bypasses stage so the output appears
    // one cycle after it is sampled.
    always_comb begin
        state_d     = state_q;
        exp_idx_d   = exp_idx_q;
        n_m1_lat_d  = n_m1_lat_q;
        stage_d     = stage_q;
        tdata_d     = tdata_q;
        tvalid_d    = '0;
        frame_err_d = 1'b0;
        start       = 1'b0;
        complete    = 1'b0;
        last_idx    = n_m1_lat_q;

        if (tvalid_in) begin
            if (state_q == SYNC) begin
                start = (tuser_in == '0);
            end else if (tuser_in == exp_idx_q) begin
                for (int k = 0; k < N_ANTENNAS; k++) begin
                    if (USR_ID_BW'(k) == exp_idx_q) begin
                        stage_d[k] = tdata_in;
                    end
                end
                if (exp_idx_q == n_m1_lat_q) begin
                    complete = 1'b1;
                end else begin
                    exp_idx_d = exp_idx_q + USR_ID_BW'(1);
                end
            end else begin
                frame_err_d = 1'b1;
                start       = (tuser_in == '0);
                if (tuser_in != '0) begin
                    state_d   = SYNC;
                    exp_idx_d = '0;
                end
            end
        end

        // An antenna-0 beat opens a frame, possibly a one-lane frame that
        // completes immediately.
        if (start) begin
            stage_d[0] = tdata_in;
            n_m1_lat_d = ant_clamped;
            last_idx   = ant_clamped;
            if (ant_clamped == '0) begin
                complete = 1'b1;
            end else begin
                exp_idx_d = USR_ID_BW'(1);
                state_d   = COLLECT;
            end
        end

        if (complete) begin
            for (int k = 0; k < N_ANTENNAS; k++) begin
                if (USR_ID_BW'(k) <= last_idx) begin
                    tvalid_d[k] = 1'b1;
                    tdata_d[k]  = (USR_ID_BW'(k) == last_idx) ? tdata_in : stage_q[k];
                end
            end
            state_d   = SYNC;
            exp_idx_d = '0;
        end
    end

    // State, staging and output registers.
    always_ff @(posedge clk_4x) begin
        if (reset_4x) begin
            state_q     <= SYNC;
            exp_idx_q   <= '0;
            n_m1_lat_q  <= '0;
            tvalid_q    <= '0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < N_ANTENNAS; k++) begin
                stage_q[k] <= '0;
                tdata_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            exp_idx_q   <= exp_idx_d;
            n_m1_lat_q  <= n_m1_lat_d;
            tvalid_q    <= tvalid_d;
            frame_err_q <= frame_err_d;
            stage_q     <= stage_d;
            tdata_q     <= tdata_d;
        end
    end

    // Violation counter updates on the same edge that registers frame_err.
    jb_prach_sat_cnt #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk (clk_4x),
        .rst (reset_4x),
        .clr (err_clr),
        .inc (frame_err_d),
        .cnt (err_cnt)
    );

    assign tvalid_out = tvalid_q;
    assign tdata_out  = tdata_q;
    assign frame_err  = frame_err_q;

endmodule
